// File: rtl/fe_pkg.sv
// Shared types and width defaults for the instruction-fetch stage.
package fe_pkg;

  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned INSTR_W_DEF     = 16;
  localparam int unsigned INSTR_BYTES_DEF = 2;
  localparam int unsigned RAS_DEPTH_DEF   = 4;

  typedef enum logic [2:0] {
    JUMP = 3'd0,
    CALL = 3'd1,
    RET  = 3'd2,
    BRZ  = 3'd3,
    BRN  = 3'd4
  } redir_kind_t;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    BUBBLE
  } fe_state_t;

  // Unconditional kinds always redirect; branches only when their flag is set.
  function automatic logic redir_taken(input redir_kind_t kind, input logic flag_z,
                                       input logic flag_n);
    logic taken;
    taken = 1'b0;
    case (kind)
      JUMP, CALL, RET: taken = 1'b1;
      BRZ:             taken = flag_z;
      BRN:             taken = flag_n;
      default:         taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fe_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; count saturates at DEPTH. Callers never push and pop together.
module fe_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   count;

  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));

  // Entry storage: write slot at ptr, which is also the oldest slot when full.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) begin
        count <= count + (PTR_W+1)'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/fetch_stage_ras.sv
// Instruction-fetch stage: PC register, next-PC selection, RUN/STALL/BUBBLE
// control and the FE/DE output register, with a return-address stack.
module fetch_stage_ras
  import fe_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       INSTR_W     = INSTR_W_DEF,
  parameter int unsigned       INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int unsigned       RAS_DEPTH   = RAS_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redir_valid,
  input  redir_kind_t        redir_kind,
  input  logic [ADDR_W-1:0]  redir_pc,
  input  logic [ADDR_W-1:0]  redir_target,
  input  logic               flag_z,
  input  logic               flag_n,
  output logic               fe_valid,
  output logic [ADDR_W-1:0]  fe_pc,
  output logic [INSTR_W-1:0] fe_instr,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  fe_state_t         state;
  logic [ADDR_W-1:0] pc;
  logic              taken;
  logic              is_call;
  logic              is_ret;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic              ras_full;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] target;

  assign imem_addr = pc;

  // Redirect decode and target selection (RET on an empty stack falls back to RESET_PC).
  always_comb begin
    taken    = redir_valid && redir_taken(redir_kind, flag_z, flag_n);
    is_call  = (redir_kind == CALL);
    is_ret   = (redir_kind == RET);
    ras_push = taken && is_call;
    ras_pop  = taken && is_ret && !ras_empty;
    ret_addr = redir_pc + ADDR_W'(INSTR_BYTES);
    target   = redir_target;
    if (is_ret) begin
      target = ras_empty ? RESET_PC : ras_top;
    end
  end

  fe_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // PC, FSM and FE register: reset > taken redirect > stall > sequential fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      fe_valid      <= 1'b0;
      fe_pc         <= '0;
      fe_instr      <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      state         <= RUN;
    end else if (taken) begin
      pc       <= target;
      fe_valid <= 1'b0;
      state    <= BUBBLE;
      if (ras_push && ras_full) begin
        ras_overflow <= 1'b1;
      end
      if (is_ret && ras_empty) begin
        ras_underflow <= 1'b1;
      end
    end else if (stall) begin
      // A stall during a bubble keeps the bubble; fe_valid is already 0.
      state <= (state == BUBBLE) ? BUBBLE : STALL;
    end else begin
      pc       <= pc + ADDR_W'(INSTR_BYTES);
      fe_valid <= 1'b1;
      fe_pc    <= pc;
      fe_instr <= imem_rdata;
      state    <= RUN;
    end
  end

endmodule
